ascon_aead_ctrl: RTL and testbench

Parametrised successor to the single-shot Ascon encrypt-then-decrypt sequencer. It sits between a request/response host interface and an external Ascon core, which drives level `*_start` / samples `*_ready`. It adds selectable mode (encrypt, decrypt, round-trip self-test), optional redundant-encryption fault detection, a per-phase watchdog, valid/ready handshakes on both sides, and a saturating job counter.

---
 rtl/ascon_aead_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ascon_aead_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_aead_ctrl.sv
// Host-side sequencer for an external Ascon core: encrypt, decrypt or round-trip jobs,
// optional double-encryption fault check, per-phase watchdog and a saturating job counter.
module ascon_aead_ctrl #(
  parameter int Y       = 40,
  parameter int T       = 128,
  parameter int FP      = 1,
  parameter int TIMEOUT = 1024,
  parameter int JC_W    = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      mode_i,
  input  logic [Y-1:0]    in_text_i,
  input  logic [T-1:0]    in_tag_i,
  output logic            core_enc_start_o,
  output logic            core_dec_start_o,
  output logic [Y-1:0]    core_ct_in_o,
  input  logic            core_enc_ready_i,
  input  logic            core_dec_ready_i,
  input  logic [Y-1:0]    core_ct_i,
  input  logic [Y-1:0]    core_pt_i,
  input  logic [T-1:0]    core_tag_i,
  input  logic [T-1:0]    core_dec_tag_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [Y-1:0]    out_text_o,
  output logic [T-1:0]    out_tag_o,
  output logic            auth_ok_o,
  output logic [2:0]      err_o,
  output logic            busy_o,
  output logic [JC_W-1:0] job_count_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, ENC1, GAP, ENC2, DEC, CMP, RESP
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [Y-1:0]    inText_q, inText_d;
  logic [T-1:0]    inTag_q, inTag_d;
  logic [Y-1:0]    ct1_q, ct1_d;
  logic [T-1:0]    tag1_q, tag1_d;
  logic [Y-1:0]    pt_q, pt_d;
  logic [T-1:0]    dtag_q, dtag_d;
  logic            encStart_q, encStart_d;
  logic            decStart_q, decStart_d;
  logic [Y-1:0]    ctIn_q, ctIn_d;
  logic            outValid_q, outValid_d;
  logic [Y-1:0]    outText_q, outText_d;
  logic [T-1:0]    outTag_q, outTag_d;
  logic            authOk_q, authOk_d;
  logic [2:0]      err_q, err_d;
  logic [JC_W-1:0] jobCount_q, jobCount_d;
  logic [WD_W-1:0] wdCnt_q, wdCnt_d;

  logic wdExpired;
  logic encMatch;
  logic decTagOk;
  logic rtOk;
  logic waiting;

  // Comparisons are full-width XOR reductions so their timing never depends on data.
  assign wdExpired = (wdCnt_q == WD_W'(TIMEOUT - 1));
  assign encMatch  = ~|({core_ct_i, core_tag_i} ^ {ct1_q, tag1_q});
  assign decTagOk  = ~|(dtag_q ^ inTag_q);
  assign rtOk      = (~|(dtag_q ^ tag1_q)) & (~|(pt_q ^ inText_q));
  assign waiting   = (state_q == ENC1) || (state_q == ENC2) || (state_q == DEC);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      inText_q   <= '0;
      inTag_q    <= '0;
      ct1_q      <= '0;
      tag1_q     <= '0;
      pt_q       <= '0;
      dtag_q     <= '0;
      encStart_q <= 1'b0;
      decStart_q <= 1'b0;
      ctIn_q     <= '0;
      outValid_q <= 1'b0;
      outText_q  <= '0;
      outTag_q   <= '0;
      authOk_q   <= 1'b0;
      err_q      <= '0;
      jobCount_q <= '0;
      wdCnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      inText_q   <= inText_d;
      inTag_q    <= inTag_d;
      ct1_q      <= ct1_d;
      tag1_q     <= tag1_d;
      pt_q       <= pt_d;
      dtag_q     <= dtag_d;
      encStart_q <= encStart_d;
      decStart_q <= decStart_d;
      ctIn_q     <= ctIn_d;
      outValid_q <= outValid_d;
      outText_q  <= outText_d;
      outTag_q   <= outTag_d;
      authOk_q   <= authOk_d;
      err_q      <= err_d;
      jobCount_q <= jobCount_d;
      wdCnt_q    <= wdCnt_d;
    end
  end

  // A ready seen in the expiry cycle wins over the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          case (mode_i)
            2'b00, 2'b10: state_d = ENC1;
            2'b01:        state_d = DEC;
            default:      state_d = CMP;
          endcase
        end
      end
      ENC1: begin
        if (core_enc_ready_i) begin
          if (FP != 0)              state_d = GAP;
          else if (mode_q == 2'b10) state_d = DEC;
          else                      state_d = CMP;
        end else if (wdExpired) begin
          state_d = CMP;
        end
      end
      GAP: state_d = ENC2;
      ENC2: begin
        if (core_enc_ready_i) begin
          if (!encMatch)            state_d = CMP;
          else if (mode_q == 2'b10) state_d = DEC;
          else                      state_d = CMP;
        end else if (wdExpired) begin
          state_d = CMP;
        end
      end
      DEC: begin
        if (core_dec_ready_i || wdExpired) state_d = CMP;
      end
      CMP: state_d = RESP;
      RESP: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Starts track residence in a wait state, so leaving one always gives a low cycle.
  always_comb begin
    mode_d     = mode_q;
    inText_d   = inText_q;
    inTag_d    = inTag_q;
    ct1_d      = ct1_q;
    tag1_d     = tag1_q;
    pt_d       = pt_q;
    dtag_d     = dtag_q;
    ctIn_d     = ctIn_q;
    outValid_d = outValid_q;
    outText_d  = outText_q;
    outTag_d   = outTag_q;
    authOk_d   = authOk_q;
    err_d      = err_q;
    jobCount_d = jobCount_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          mode_d   = mode_i;
          inText_d = in_text_i;
          inTag_d  = in_tag_i;
          authOk_d = 1'b0;
          err_d    = 3'b000;
          if (mode_i == 2'b11) err_d[2] = 1'b1;
        end
      end
      ENC1: begin
        if (core_enc_ready_i) begin
          ct1_d  = core_ct_i;
          tag1_d = core_tag_i;
        end else if (wdExpired) begin
          err_d[0] = 1'b1;
        end
      end
      ENC2: begin
        if (core_enc_ready_i) begin
          if (!encMatch) err_d[1] = 1'b1;
        end else if (wdExpired) begin
          err_d[0] = 1'b1;
        end
      end
      DEC: begin
        if (core_dec_ready_i) begin
          pt_d   = core_pt_i;
          dtag_d = core_dec_tag_i;
        end else if (wdExpired) begin
          err_d[0] = 1'b1;
        end
      end
      CMP: begin
        outValid_d = 1'b1;
        outText_d  = '0;
        outTag_d   = '0;
        authOk_d   = 1'b0;
        if (err_q == 3'b000) begin
          case (mode_q)
            2'b00: begin
              outText_d = ct1_q;
              outTag_d  = tag1_q;
            end
            2'b01: begin
              outText_d = pt_q;
              outTag_d  = dtag_q;
              authOk_d  = decTagOk;
            end
            2'b10: begin
              outText_d = ct1_q;
              outTag_d  = tag1_q;
              authOk_d  = rtOk;
            end
            default: ;
          endcase
        end
      end
      RESP: begin
        if (out_ready_i) begin
          outValid_d = 1'b0;
          if ((err_q == 3'b000) && (jobCount_q != {JC_W{1'b1}}))
            jobCount_d = jobCount_q + JC_W'(1);
        end
      end
      default: ;
    endcase

    if ((state_d == DEC) && (state_q != DEC))
      ctIn_d = (state_q == IDLE) ? in_text_i : ct1_d;

    encStart_d = (state_d == ENC1) || (state_d == ENC2);
    decStart_d = (state_d == DEC);
    wdCnt_d    = (waiting && (state_d == state_q)) ? wdCnt_q + WD_W'(1) : '0;
  end

  always_comb begin
    req_ready_o      = (state_q == IDLE) & ~rst_i;
    busy_o           = (state_q != IDLE);
    core_enc_start_o = encStart_q;
    core_dec_start_o = decStart_q;
    core_ct_in_o     = ctIn_q;
    out_valid_o      = outValid_q;
    out_text_o       = outText_q;
    out_tag_o        = outTag_q;
    auth_ok_o        = authOk_q;
    err_o            = err_q;
    job_count_o      = jobCount_q;
  end

endmodule

// File: tb/tb_ascon_aead_ctrl.sv
// Directed bench for ascon_aead_ctrl: instance 0 runs single-pass (FP=0), instance 1 runs
// double-encryption (FP=1); both use a short watchdog and a stub core with fixed latency.
module tb_ascon_aead_ctrl;

  localparam int Y  = 40;
  localparam int T  = 128;
  localparam int JW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    reqValid, reqReady, encStart, decStart, outValid, outReady, authOk, busy;
  logic [1:0]    encEn, decEn;
  logic [1:0]    mode     [2];
  logic [Y-1:0]  inText   [2];
  logic [Y-1:0]  ctIn     [2];
  logic [Y-1:0]  outText  [2];
  logic [Y-1:0]  ctVal    [2];
  logic [Y-1:0]  ptVal    [2];
  logic [T-1:0]  inTag    [2];
  logic [T-1:0]  outTag   [2];
  logic [T-1:0]  tag1Val  [2];
  logic [T-1:0]  tag2Val  [2];
  logic [T-1:0]  dtagVal  [2];
  logic [2:0]    err      [2];
  logic [JW-1:0] jobCount [2];
  int            dly = 5;

  int checkCount = 0;
  int passCount  = 0;

  int           lat, encHigh, decHigh, readyLeak;
  logic         stableOk, postValid, postReady;
  logic [Y-1:0] respText, respCtIn;
  logic [T-1:0] respTag;
  logic [2:0]   respErr;
  logic         respAuth;

  // The stub core raises ready for one cycle, dly cycles after it first sees start high;
  // its encryption tag switches to tag2Val after the first completed pass of a job.
  for (genvar g = 0; g < 2; g++) begin : gInst
    logic eRdy = 1'b0;
    logic dRdy = 1'b0;
    int   eCnt = 0;
    int   dCnt = 0;
    int   ePass = 0;

    ascon_aead_ctrl #(.Y(Y), .T(T), .FP(g), .TIMEOUT(16), .JC_W(JW)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .req_valid_i      (reqValid[g]),
      .req_ready_o      (reqReady[g]),
      .mode_i           (mode[g]),
      .in_text_i        (inText[g]),
      .in_tag_i         (inTag[g]),
      .core_enc_start_o (encStart[g]),
      .core_dec_start_o (decStart[g]),
      .core_ct_in_o     (ctIn[g]),
      .core_enc_ready_i (eRdy),
      .core_dec_ready_i (dRdy),
      .core_ct_i        (ctVal[g]),
      .core_pt_i        (ptVal[g]),
      .core_tag_i       ((ePass == 0) ? tag1Val[g] : tag2Val[g]),
      .core_dec_tag_i   (dtagVal[g]),
      .out_valid_o      (outValid[g]),
      .out_ready_i      (outReady[g]),
      .out_text_o       (outText[g]),
      .out_tag_o        (outTag[g]),
      .auth_ok_o        (authOk[g]),
      .err_o            (err[g]),
      .busy_o           (busy[g]),
      .job_count_o      (jobCount[g])
    );

    always @(posedge clk) begin
      if (encStart[g] !== 1'b1 || !encEn[g]) begin
        eCnt <= 0;
        eRdy <= 1'b0;
      end else begin
        eCnt <= eCnt + 1;
        eRdy <= (eCnt == dly - 1);
      end
      if (decStart[g] !== 1'b1 || !decEn[g]) begin
        dCnt <= 0;
        dRdy <= 1'b0;
      end else begin
        dCnt <= dCnt + 1;
        dRdy <= (dCnt == dly - 1);
      end
      if (busy[g] !== 1'b1) ePass <= 0;
      else if (eRdy)        ePass <= ePass + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checkCount++;
    if (got !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else
      passCount++;
  endtask

  // Runs one job end to end and records latency, start activity and the held response.
  task automatic applyStimulus(input int sel, input logic [1:0] m, input logic [Y-1:0] txt,
                               input logic [T-1:0] tg, input int hold);
    int  waitCnt;
    logic done;
    @(negedge clk);
    mode[sel]     = m;
    inText[sel]   = txt;
    inTag[sel]    = tg;
    reqValid[sel] = 1'b1;
    waitCnt = 0;
    while (!reqReady[sel] && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    @(posedge clk);
    #1;
    reqValid[sel] = 1'b0;
    encHigh   = int'(encStart[sel]);
    decHigh   = int'(decStart[sel]);
    readyLeak = int'(reqReady[sel]);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (outValid[sel]) done = 1'b1;
      else begin
        encHigh   += int'(encStart[sel]);
        decHigh   += int'(decStart[sel]);
        readyLeak += int'(reqReady[sel]);
      end
    end
    respText = outText[sel];
    respTag  = outTag[sel];
    respErr  = err[sel];
    respAuth = authOk[sel];
    respCtIn = ctIn[sel];
    stableOk = 1'b1;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (outText[sel] !== respText || outTag[sel] !== respTag || err[sel] !== respErr ||
          authOk[sel] !== respAuth || outValid[sel] !== 1'b1 || reqReady[sel] !== 1'b0)
        stableOk = 1'b0;
    end
    @(negedge clk);
    outReady[sel] = 1'b1;
    @(posedge clk);
    #1;
    outReady[sel] = 1'b0;
    postValid = outValid[sel];
    postReady = reqReady[sel];
  endtask

  localparam logic [T-1:0] TAG_RT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  initial begin
    rst      = 1'b1;
    reqValid = '0;
    outReady = '0;
    encEn    = 2'b11;
    decEn    = 2'b11;
    for (int i = 0; i < 2; i++) begin
      mode[i] = '0; inText[i] = '0; inTag[i] = '0; ctVal[i] = '0; ptVal[i] = '0;
      tag1Val[i] = '0; tag2Val[i] = '0; dtagVal[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", reqReady[0], 0);
    checkOutput("rst_out_valid", outValid[0], 0);
    checkOutput("rst_enc_start", encStart[0], 0);
    checkOutput("rst_ct_in", ctIn[0], 0);
    checkOutput("rst_err", err[0], 0);
    checkOutput("rst_job_count", jobCount[0], 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("idle_req_ready", reqReady[0], 1);

    $display("[TB] FP=0 encrypt, response held 10 cycles");
    ctVal[0] = 40'hA1B2C3D4E5; tag1Val[0] = 128'h1; tag2Val[0] = 128'h1;
    applyStimulus(0, 2'b00, 40'h1111111111, '0, 10);
    checkOutput("enc_latency", lat, 7);
    checkOutput("enc_start_cycles", encHigh, 6);
    checkOutput("enc_text", respText, 40'hA1B2C3D4E5);
    checkOutput("enc_tag", respTag, 128'h1);
    checkOutput("enc_err", respErr, 0);
    checkOutput("enc_auth", respAuth, 0);
    checkOutput("enc_hold_stable", stableOk, 1);
    checkOutput("enc_req_ready_busy", readyLeak, 0);
    checkOutput("enc_valid_after_hs", postValid, 0);
    checkOutput("enc_ready_after_hs", postReady, 1);
    checkOutput("enc_job_count", jobCount[0], 1);

    $display("[TB] decrypt with matching and mismatching tag");
    ptVal[0] = 40'h0F1E2D3C4B; dtagVal[0] = 128'hDEAD;
    applyStimulus(0, 2'b01, 40'hCAFEBABE01, 128'hDEAD, 0);
    checkOutput("dec_latency", lat, 7);
    checkOutput("dec_start_cycles", decHigh, 6);
    checkOutput("dec_no_enc", encHigh, 0);
    checkOutput("dec_ct_in", respCtIn, 40'hCAFEBABE01);
    checkOutput("dec_text", respText, 40'h0F1E2D3C4B);
    checkOutput("dec_tag", respTag, 128'hDEAD);
    checkOutput("dec_auth_ok", respAuth, 1);
    checkOutput("dec_err", respErr, 0);
    checkOutput("dec_job_count", jobCount[0], 2);
    dtagVal[0] = 128'hDEAE;
    applyStimulus(0, 2'b01, 40'hCAFEBABE01, 128'hDEAD, 0);
    checkOutput("dec_bad_auth", respAuth, 0);
    checkOutput("dec_bad_err", respErr, 0);
    checkOutput("dec_bad_tag", respTag, 128'hDEAE);
    checkOutput("dec_bad_job_count", jobCount[0], 3);

    $display("[TB] round trip, clean and with corrupted plaintext");
    ctVal[0] = 40'h5566778899; tag1Val[0] = TAG_RT; tag2Val[0] = TAG_RT;
    ptVal[0] = 40'h0123456789; dtagVal[0] = TAG_RT;
    applyStimulus(0, 2'b10, 40'h0123456789, '0, 0);
    checkOutput("rt_latency", lat, 13);
    checkOutput("rt_enc_cycles", encHigh, 6);
    checkOutput("rt_dec_cycles", decHigh, 6);
    checkOutput("rt_ct_in", respCtIn, 40'h5566778899);
    checkOutput("rt_text", respText, 40'h5566778899);
    checkOutput("rt_tag", respTag, TAG_RT);
    checkOutput("rt_auth_ok", respAuth, 1);
    checkOutput("rt_err", respErr, 0);
    checkOutput("rt_job_count", jobCount[0], 4);
    ptVal[0] = 40'h0123456788;
    applyStimulus(0, 2'b10, 40'h0123456789, '0, 0);
    checkOutput("rt_bad_auth", respAuth, 0);
    checkOutput("rt_bad_err", respErr, 0);
    checkOutput("rt_bad_job_count", jobCount[0], 5);

    $display("[TB] watchdog expiry and illegal mode");
    encEn[0] = 1'b0;
    applyStimulus(0, 2'b00, 40'h2222222222, '0, 0);
    encEn[0] = 1'b1;
    checkOutput("to_latency", lat, 17);
    checkOutput("to_start_cycles", encHigh, 16);
    checkOutput("to_err", respErr, 3'b001);
    checkOutput("to_text", respText, 0);
    checkOutput("to_tag", respTag, 0);
    checkOutput("to_auth", respAuth, 0);
    checkOutput("to_job_count", jobCount[0], 5);
    applyStimulus(0, 2'b11, 40'h3333333333, '0, 0);
    checkOutput("ill_latency", lat, 1);
    checkOutput("ill_no_enc", encHigh, 0);
    checkOutput("ill_no_dec", decHigh, 0);
    checkOutput("ill_err", respErr, 3'b100);
    checkOutput("ill_auth", respAuth, 0);
    checkOutput("ill_job_count", jobCount[0], 5);

    $display("[TB] reset while waiting in DEC");
    decEn[0] = 1'b0;
    @(negedge clk);
    mode[0] = 2'b01; inText[0] = 40'h4444444444; reqValid[0] = 1'b1;
    @(posedge clk);
    #1;
    reqValid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mid_dec_start", decStart[0], 1);
    checkOutput("mid_busy", busy[0], 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_dec_start", decStart[0], 0);
    checkOutput("abort_busy", busy[0], 0);
    checkOutput("abort_out_valid", outValid[0], 0);
    checkOutput("abort_job_count", jobCount[0], 0);
    checkOutput("abort_req_ready_in_rst", reqReady[0], 0);
    @(negedge clk);
    rst = 1'b0;
    decEn[0] = 1'b1;
    #1;
    checkOutput("abort_req_ready_after", reqReady[0], 1);

    $display("[TB] FP=1 double encryption, matching then differing second tag");
    ctVal[1] = 40'hA1B2C3D4E5; tag1Val[1] = 128'h1; tag2Val[1] = 128'h1;
    applyStimulus(1, 2'b00, 40'h5555555555, '0, 0);
    checkOutput("fp_latency", lat, 14);
    checkOutput("fp_start_cycles", encHigh, 12);
    checkOutput("fp_text", respText, 40'hA1B2C3D4E5);
    checkOutput("fp_tag", respTag, 128'h1);
    checkOutput("fp_err", respErr, 0);
    checkOutput("fp_job_count", jobCount[1], 1);
    tag2Val[1] = 128'h2;
    applyStimulus(1, 2'b00, 40'h5555555555, '0, 0);
    checkOutput("fault_latency", lat, 14);
    checkOutput("fault_err", respErr, 3'b010);
    checkOutput("fault_auth", respAuth, 0);
    checkOutput("fault_text", respText, 0);
    checkOutput("fault_tag", respTag, 0);
    checkOutput("fault_job_count", jobCount[1], 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
